div_iter_ctrl: RTL and testbench
================================

Name: div_iter_ctrl

Overview:
- Iterative 32-bit integer divider controller for the EX stage (DIV/DIVU → HI/LO).
- Sequences one shared cla_32 instance as the trial subtractor: one restoring-division step per cycle.
- Owns the operand, remainder and quotient registers, the iteration counter, the start/done/cancel handshake with the pipeline stall logic, and sign fix-up.

Parameters:
- WIDTH, 32, operand width; fixed at 32 to match cla_32. Other values are unsupported.
- DIV0_QUOT, 32'hFFFF_FFFF, quotient returned on divide-by-zero.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only when ready=1.
- cancel  in  1  pipeline flush; aborts any operation.
- div_signed  in  1  1 = DIV (signed), 0 = DIVU.
- dividend  in  32  sampled on the accept cycle.
- divisor  in  32  sampled on the accept cycle.
- ready  out  1  1 in IDLE only.
- busy  out  1  1 in RUN or FIX.
- done  out  1  one-cycle pulse; results are valid that cycle.
- quotient  out  32  result, held until the next accept.
- remainder  out  32  result, held until the next accept.

Behaviour:
- Reset: IDLE; ready=1, busy=0, done=0, quotient=0, remainder=0, counter=0. Applies mid-operation with no done pulse.
- States:
  - IDLE: start & ~cancel → LOAD operands, go to RUN; if divisor=0, go to FIX directly.
  - RUN: 32 cycles, counter 0..31; counter=31 → FIX.
  - FIX: 1 cycle; → DONE.
  - DONE: 1 cycle; done=1, ready=0; → IDLE.
- Load: a_mag = |dividend|, b_mag = |divisor| when signed, else the raw values. r=0, q=a_mag. Record sign_q = a[31]^b[31] and sign_r = a[31] (signed only).
- RUN step:
  - rs = {r, q[31]} (33 bit).
  - cla_32 A=rs[31:0], B=~b_mag, cin=1 → diff, cout (cout=1 means no borrow).
  - qbit = rs[32] | cout.
  - r ← qbit ? diff : rs[31:0].
  - q ← {q[30:0], qbit}.
- FIX: quotient = sign_q ? -q : q; remainder = sign_r ? -r : r; both registered.
- Divide by zero: quotient = DIV0_QUOT, remainder = dividend (raw).
- Latency:
  - Accept at cycle 0 → done at cycle 34.
  - Divide-by-zero: accept at cycle 0 → done at cycle 2.
- Handshake rules:
  - start while ready=0 is ignored (no queueing).
  - start and cancel in the same cycle: cancel wins, nothing accepted.
  - cancel in RUN/FIX/DONE → IDLE next cycle; done suppressed; quotient/remainder keep their previous values.
  - A new start may be accepted in the cycle after a cancel.
- Boundaries:
  - 0x8000_0000 / -1 signed → q=0x8000_0000, r=0 (natural wrap, no trap).
  - Dividend 0 → q=0, r=0.
  - Counter wraps to 0 on RUN exit.

Optional Feature:
- Macro DIV_SIGNED_EN.
- Defined: div_signed is honoured, with magnitude conversion at load and sign fix-up in FIX.
- Undefined: div_signed is ignored; all operations are unsigned; FIX still takes one cycle, so latency is unchanged. Removes the negation logic.

Decomposition:
- Shared header div_defs.vh: state encodings (IDLE, RUN, FIX, DONE), ITER_LAST=31, DIV0_QUOT default.
- One sub-module: the existing cla_32, instantiated once as the subtractor.
- Magnitude/negate logic stays inline.

Test Plan:
- DIVU 100 / 7 → done at cycle 34; q=14, r=2; busy=1 in cycles 1–33.
- DIV -7 / 2 → q=0xFFFF_FFFD, r=0xFFFF_FFFF. DIV 7 / -2 → q=0xFFFF_FFFD, r=1.
- DIV 0x8000_0000 / 0xFFFF_FFFF → q=0x8000_0000, r=0. DIVU 0xFFFF_FFFF / 1 → q=0xFFFF_FFFF, r=0.
- DIVU 55 / 0 → done at cycle 2; q=0xFFFF_FFFF, r=55.
- Accept 100/7, cancel at cycle 10 → IDLE at cycle 11, no done. Start 9/3 at cycle 11 → done at cycle 45; q=3, r=0. A start at cycle 5 of the first op is ignored.
- reset asserted at cycle 20 of an op → all outputs 0 immediately, ready=1; no done.

Source files
------------

// File: rtl/div_iter_ctrl_pkg.sv
// Shared definitions for the iterative divider controller.
//   - FSM state encoding (IDLE, RUN, FIX, DONE)
//   - operand width, iteration counter width and last-iteration value
//   - default quotient returned on divide-by-zero
// Optional feature macro used by the design: DIV_SIGNED_EN (signed DIV support).
package div_iter_ctrl_pkg;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 5;

   localparam logic [CNT_W-1:0]  ITER_LAST     = 5'd31;
   localparam logic [DATA_W-1:0] DIV0_QUOT_DEF = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } div_state_e;

endpackage

// File: rtl/div_iter_ctrl_if.sv
// Pipeline <-> divider handshake and data bundle.
//   master : EX-stage side (drives start/cancel/operands, observes status/results)
//   slave  : divider side
// Signals:
//   start, cancel, div_signed      request, flush, signed-op select
//   dividend, divisor [31:0]       operands, sampled on the accept cycle
//   ready, busy, done              status; done is a one-cycle result strobe
//   quotient, remainder [31:0]     results, held until the next accept
interface div_iter_ctrl_if;
   import div_iter_ctrl_pkg::*;

   logic              start;
   logic              cancel;
   logic              div_signed;
   logic [DATA_W-1:0] dividend;
   logic [DATA_W-1:0] divisor;
   logic              ready;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] quotient;
   logic [DATA_W-1:0] remainder;

   modport master (
      output start, cancel, div_signed, dividend, divisor,
      input  ready, busy, done, quotient, remainder
   );

   modport slave (
      input  start, cancel, div_signed, dividend, divisor,
      output ready, busy, done, quotient, remainder
   );

endinterface

// File: rtl/div_iter_ctrl_cla_32.sv
// 32-bit carry-lookahead adder: sum = a + b + cin, cout = carry out of bit 31.
// Built from eight 4-bit lookahead groups with a group-carry chain.
// Ports:
//   a, b [31:0]  addends
//   cin          carry in
//   sum [31:0]   result
//   cout         carry out
module cla_32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);

   logic [31:0] g;
   logic [31:0] p;
   logic [31:0] c;
   logic [8:0]  cg;
   logic [3:0]  gg;
   logic [3:0]  pp;
   logic        ci;

   always_comb begin
      g  = a & b;
      p  = a ^ b;
      c  = '0;
      cg = '0;
      gg = '0;
      pp = '0;
      ci = 1'b0;
      cg[0] = cin;
      for (int i = 0; i < 8; i++) begin
         gg = g[4*i +: 4];
         pp = p[4*i +: 4];
         ci = cg[i];
         c[4*i]   = ci;
         c[4*i+1] = gg[0] | (pp[0] & ci);
         c[4*i+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
         c[4*i+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                  | (pp[2] & pp[1] & pp[0] & ci);
         cg[i+1]  = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                  | (pp[3] & pp[2] & pp[1] & gg[0]) | ((&pp) & ci);
      end
   end

   assign sum  = p ^ c;
   assign cout = cg[8];

endmodule

// File: rtl/div_iter_ctrl.sv
// Iterative 32-bit restoring divider controller (DIV/DIVU -> HI/LO).
// One quotient bit per cycle using a single shared cla_32 as trial subtractor.
// Accept at cycle 0 -> done at cycle 34; divide-by-zero -> done at cycle 2.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready=1; waiting for start (cancel in the same cycle wins)
// RUN   | 32 restoring steps, counter 0..31
// FIX   | one cycle: sign fix-up, results registered
// DONE  | one cycle: done=1, results valid
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high
//   bus    div_iter_ctrl_if.slave (handshake, operands, results)
// Parameters:
//   WIDTH      operand width, must be 32 (matches cla_32)
//   DIV0_QUOT  quotient returned on divide-by-zero
// Build option:
//   DIV_SIGNED_EN  defined   : div_signed honoured (magnitude at load, negate in FIX)
//                  undefined : all operations unsigned, latency unchanged
module div_iter_ctrl
   import div_iter_ctrl_pkg::*;
#(
   parameter int               WIDTH     = DATA_W,
   parameter logic [WIDTH-1:0] DIV0_QUOT = DIV0_QUOT_DEF
) (
   input  logic           clk,
   input  logic           reset,
   div_iter_ctrl_if.slave bus
);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] wq_q, wq_d;
   logic [WIDTH-1:0] wr_q, wr_d;
   logic [WIDTH-1:0] bmag_q, bmag_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;

   logic             accept;
   logic             div0;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH-1:0] fix_quot;
   logic [WIDTH-1:0] fix_rem;

   logic [WIDTH:0]   rs;
   logic [WIDTH-1:0] diff;
   logic             cout;
   logic             qbit;

   assign accept = (state_q == ST_IDLE) & bus.start & ~bus.cancel;
   assign div0   = (bus.divisor == '0);

`ifdef DIV_SIGNED_EN
   logic neg_a;
   logic neg_b;
   logic qsign_q;
   logic rsign_q;

   assign neg_a = bus.div_signed & bus.dividend[WIDTH-1];
   assign neg_b = bus.div_signed & bus.divisor[WIDTH-1];
   assign a_mag = neg_a ? -bus.dividend : bus.dividend;
   assign b_mag = neg_b ? -bus.divisor  : bus.divisor;

   // Divide-by-zero results are returned raw, so no sign is recorded for them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         qsign_q <= 1'b0;
         rsign_q <= 1'b0;
      end else if (accept) begin
         qsign_q <= (neg_a ^ neg_b) & ~div0;
         rsign_q <= neg_a & ~div0;
      end
   end

   assign fix_quot = qsign_q ? -wq_q : wq_q;
   assign fix_rem  = rsign_q ? -wr_q : wr_q;
`else
   logic div_signed_unused;

   assign div_signed_unused = bus.div_signed;
   assign a_mag    = bus.dividend;
   assign b_mag    = bus.divisor;
   assign fix_quot = wq_q;
   assign fix_rem  = wr_q;
`endif

   // Trial subtract: rs[31:0] - b_mag; cout=1 means no borrow.
   assign rs = {wr_q, wq_q[WIDTH-1]};

   cla_32 u_sub (
      .a    (rs[WIDTH-1:0]),
      .b    (~bmag_q),
      .cin  (1'b1),
      .sum  (diff),
      .cout (cout)
   );

   // rs[32] set means the shifted remainder already exceeds 2^32 > b_mag.
   assign qbit = rs[WIDTH] | cout;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wq_d    = wq_q;
      wr_d    = wr_q;
      bmag_d  = bmag_q;
      quot_d  = quot_q;
      rem_d   = rem_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               cnt_d  = '0;
               bmag_d = b_mag;
               if (div0) begin
                  wq_d    = DIV0_QUOT;
                  wr_d    = bus.dividend;
                  state_d = ST_FIX;
               end else begin
                  wq_d    = a_mag;
                  wr_d    = '0;
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            wr_d  = qbit ? diff : rs[WIDTH-1:0];
            wq_d  = {wq_q[WIDTH-2:0], qbit};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == ITER_LAST) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            quot_d  = fix_quot;
            rem_d   = fix_rem;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Flush: abort without touching the visible results.
      if (bus.cancel && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         quot_d  = quot_q;
         rem_d   = rem_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         wq_q    <= '0;
         wr_q    <= '0;
         bmag_q  <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wq_q    <= wq_d;
         wr_q    <= wr_d;
         bmag_q  <= bmag_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
      end
   end

   assign bus.ready     = (state_q == ST_IDLE);
   assign bus.busy      = (state_q == ST_RUN) | (state_q == ST_FIX);
   assign bus.done      = (state_q == ST_DONE) & ~bus.cancel;
   assign bus.quotient  = quot_q;
   assign bus.remainder = rem_q;

endmodule

// File: tb/tb_div_iter_ctrl.sv
// Scoreboard bench for div_iter_ctrl: stimulus pushes expected results (value
// and done cycle) from an arithmetic reference model; a monitor pops and
// compares on every done pulse.
module tb_div_iter_ctrl;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      int          cyc;
   } exp_t;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   int          cyc   = 0;
   int          total = 0;
   int          bad   = 0;
   logic [31:0] last_q = '0;
   logic [31:0] last_r = '0;
   exp_t        exp_q[$];
   exp_t        mon_e;

   div_iter_ctrl_if bus();

   div_iter_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=0x%08h required=0x%08h cyc=%0d", name, act, req, cyc);
      end
   endtask

   // Reference: plain integer division with the divider's special cases.
   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                 output logic [31:0] q, output logic [31:0] r);
      int sa;
      int sb;
      sa = $signed(a);
      sb = $signed(b);
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'd0;
      end else if (sgn) begin
         q = 32'(sa / sb);
         r = 32'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   always @(negedge clk) begin
      if (!reset && bus.done) begin
         if (exp_q.size() == 0) begin
            chk("done_unexpected_queue_depth", 32'(exp_q.size()), 32'd1);
         end else begin
            mon_e = exp_q.pop_front();
            chk("quotient", bus.quotient, mon_e.q);
            chk("remainder", bus.remainder, mon_e.r);
            chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
            last_q = mon_e.q;
            last_r = mon_e.r;
         end
      end
   end

   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s, output int c);
      logic [31:0] mq;
      logic [31:0] mr;
      logic        eff;
      exp_t        e;
      bus.start      = 1'b1;
      bus.dividend   = a;
      bus.divisor    = b;
      bus.div_signed = s;
      c = cyc;
`ifdef DIV_SIGNED_EN
      eff = s;
`else
      eff = 1'b0;
`endif
      model(a, b, eff, mq, mr);
      e.q   = mq;
      e.r   = mr;
      e.cyc = c + ((b == 32'd0) ? 2 : 34);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      bus.start      = 1'b0;
      bus.dividend   = $urandom;
      bus.divisor    = $urandom;
      bus.div_signed = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!bus.ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", 32'(bus.ready), 32'd1);
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, output int c);
      wait_ready();
      @(posedge clk);
      #1;
      drive(a, b, s, c);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_queue_depth", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   logic [31:0] da[8] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF,
                          32'd55, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF};
   logic [31:0] db[8] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1,
                          32'd0, 32'd12345, 32'd0, 32'hFFFF_FFFF};
   logic        ds[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

   initial begin
      int          c;
      int          c2;
      logic [31:0] a;
      logic [31:0] b;
      logic        s;

      bus.start      = 1'b0;
      bus.cancel     = 1'b0;
      bus.div_signed = 1'b0;
      bus.dividend   = '0;
      bus.divisor    = '0;

      repeat (3) @(negedge clk);
      chk("reset_ready", 32'(bus.ready), 32'd1);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_done", 32'(bus.done), 32'd0);
      chk("reset_quotient", bus.quotient, 32'd0);
      chk("reset_remainder", bus.remainder, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // DIVU 100/7 with busy/ready profile over the whole operation
      issue(32'd100, 32'd7, 1'b0, c);
      repeat (34) begin
         @(negedge clk);
         chk("busy_profile", 32'(bus.busy), 32'(((cyc - c) >= 1) && ((cyc - c) <= 33)));
         chk("ready_low", 32'(bus.ready), 32'd0);
      end
      drain();

      for (int i = 0; i < 8; i++) begin
         issue(da[i], db[i], ds[i], c);
      end
      drain();

      // Cancel mid-RUN, ignored start while busy, restart right after cancel
      issue(32'd100, 32'd7, 1'b0, c);
      repeat (4) @(posedge clk);
      #1;
      bus.start    = 1'b1;
      bus.dividend = 32'd1;
      bus.divisor  = 32'd1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      bus.cancel = 1'b1;
      exp_q.delete(exp_q.size() - 1);
      @(posedge clk);
      #1;
      bus.cancel = 1'b0;
      chk("cancel_ready", 32'(bus.ready), 32'd1);
      chk("cancel_busy", 32'(bus.busy), 32'd0);
      chk("cancel_hold_quotient", bus.quotient, last_q);
      chk("cancel_hold_remainder", bus.remainder, last_r);
      drive(32'd9, 32'd3, 1'b0, c2);
      chk("restart_cycle_offset", 32'(c2 - c), 32'd11);
      drain();

      // start and cancel together in IDLE: nothing accepted
      wait_ready();
      @(posedge clk);
      #1;
      bus.start    = 1'b1;
      bus.cancel   = 1'b1;
      bus.dividend = 32'd5;
      bus.divisor  = 32'd1;
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      bus.cancel = 1'b0;
      chk("start_cancel_ready", 32'(bus.ready), 32'd1);
      chk("start_cancel_busy", 32'(bus.busy), 32'd0);
      repeat (40) @(negedge clk);

      // Reset mid-operation
      issue(32'd1000, 32'd3, 1'b0, c);
      repeat (19) @(posedge clk);
      #1;
      reset = 1'b1;
      exp_q.delete(exp_q.size() - 1);
      #1;
      chk("midreset_ready", 32'(bus.ready), 32'd1);
      chk("midreset_busy", 32'(bus.busy), 32'd0);
      chk("midreset_done", 32'(bus.done), 32'd0);
      chk("midreset_quotient", bus.quotient, 32'd0);
      chk("midreset_remainder", bus.remainder, 32'd0);
      last_q = '0;
      last_r = '0;
      @(posedge clk);
      #1;
      reset = 1'b0;

      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         case ($urandom_range(0, 4))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 15);
            2:       b = $urandom;
            3: begin b = $urandom; a = 32'd0; end
            default: b = 32'hFFFF_FFFF;
         endcase
         s = 1'($urandom_range(0, 1));
         issue(a, b, s, c);
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
